// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: latency-class codes
// that the decoder also produces, and a small classification helper.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_DIV  = 2'd3
  } lat_class_e;

  localparam int NUM_REGS = 32;

  // MUL and DIV share the iterative unit, so both must wait for it.
  function automatic logic uses_divider(input lat_class_e c);
    return (c == LAT_MUL) || (c == LAT_DIV);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_stall_counter.sv
// Loadable down-counter with hold. A load wins over the same-cycle decrement;
// the counter parks at zero and flags when it is nonzero.
module stall_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage producer tracker: one countdown per architectural register plus the
// divider occupancy, compared against the instruction in ID to request stalls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int MUL_STALL  = 2,
  parameter int DIV_STALL  = 33,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd_addr,
  input  logic       id_reg_write,
  input  logic [1:0] id_lat_class,
  input  logic       pipe_hold,
  input  logic       id_flush,
  output logic       stall,
  output logic       issue,
  output logic       div_busy
);

  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  if (LOAD_STALL > CNT_MAX || MUL_STALL > CNT_MAX || DIV_STALL > CNT_MAX) begin : g_bad_cnt_w
    $error("hazard_scoreboard: CNT_W too narrow for configured stall latencies");
  end

  localparam logic [CNT_W-1:0] L_LOAD = CNT_W'(LOAD_STALL);
  localparam logic [CNT_W-1:0] L_MUL  = CNT_W'(MUL_STALL);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_STALL);

  lat_class_e       cls;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] cnt_nz;
  logic [CNT_W-1:0] div_cnt;
  logic             div_nz;
  logic             raw, waw, struc;
  logic             wr_track;

  assign cls = lat_class_e'(id_lat_class);

  always_comb begin
    lat = '0;
    case (cls)
      LAT_LOAD: lat = L_LOAD;
      LAT_MUL:  lat = L_MUL;
      LAT_DIV:  lat = L_DIV;
      default:  lat = '0;
    endcase
  end

  assign wr_track = id_reg_write && (id_rd_addr != 5'd0);

  assign raw   = (id_uses_rs1 && cnt_nz[id_rs1_addr]) ||
                 (id_uses_rs2 && cnt_nz[id_rs2_addr]);
  // A younger write must not land in the register file before an older one.
  assign waw   = wr_track && (cnt[id_rd_addr] > lat);
  assign struc = uses_divider(cls) && (div_cnt != '0);

  assign stall    = id_valid && (raw || waw || struc);
  assign issue    = id_valid && !stall && !pipe_hold && !id_flush;
  assign div_busy = div_nz;

  // x0 is hardwired: never tracked, always reads as ready.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt[r]    = '0;
      assign cnt_nz[r] = 1'b0;
    end else begin : g_cnt
      stall_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (pipe_hold),
        .load_i     (issue && wr_track && (id_rd_addr == 5'(r))),
        .load_val_i (lat),
        .cnt_o      (cnt[r]),
        .nz_o       (cnt_nz[r])
      );
    end
  end

  stall_counter #(.CNT_W(CNT_W)) u_div_cnt (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (pipe_hold),
    .load_i     (issue && (cls == LAT_DIV)),
    .load_val_i (L_DIV),
    .cnt_o      (div_cnt),
    .nz_o       (div_nz)
  );

endmodule
